// File: rtl/vend_pkg.sv
`default_nettype none
// --------------------------------------------------------------------------
// vend_pkg: shared types and limits for the vending dispense path. Rev 1.0
// --------------------------------------------------------------------------
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GO   = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   localparam int DEFAULT_TIMEOUT = 255;
   localparam int MAX_CH          = 8;

endpackage
`default_nettype wire

// File: rtl/dispense_arbiter_rr_picker.sv
`default_nettype none
// --------------------------------------------------------------------------
// rr_picker: first set request at or after ptr, wrapping modulo N. Rev 1.0
// --------------------------------------------------------------------------
module rr_picker #(
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] win,
   output logic            valid
);

   logic [N-1:0]  w_rot;
   logic [SELW:0] w_off;
   logic [SELW:0] w_sum;

   // Rotate so bit 0 is the channel at ptr; lowest set bit is the winner.
   always_comb begin
      w_rot = N'({req, req} >> ptr);
      valid = |w_rot;
      w_off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = (SELW + 1)'(k);
      end
      w_sum = {1'b0, ptr} + w_off;
      if (w_sum >= (SELW + 1)'(N)) w_sum = w_sum - (SELW + 1)'(N);
      win = w_sum[SELW-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/dispense_arbiter.sv
`default_nettype none
// --------------------------------------------------------------------------
// dispense_arbiter: round-robin sharing of one dispense motor, with timeout.
// Rev 1.0
// --------------------------------------------------------------------------
module dispense_arbiter
   import vend_pkg::*;
#(
   parameter int N       = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int SELW    = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            motor_ready,
   input  logic            motor_done,
   output logic            motor_go,
   output logic [SELW-1:0] motor_sel,
   output logic [N-1:0]    grant,
   output logic [N-1:0]    ack,
   output logic [N-1:0]    fault,
   output logic            busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_t      r_state, w_state_nx;
   logic [SELW-1:0] r_ptr, w_ptr_nx;
   logic [SELW-1:0] r_idx, w_idx_nx;
   logic            r_ok, w_ok_nx;
   logic            r_mask, w_mask_nx;
   logic [TW-1:0]   r_timer, w_timer_nx;

   logic [N-1:0]    w_oh;
   logic [N-1:0]    w_elig;
   logic [SELW-1:0] w_pick;
   logic            w_pick_valid;

   assign w_oh   = N'(1) << r_idx;
   // The channel just served sits out one IDLE cycle so it can drop req.
   assign w_elig = req & ~(r_mask ? w_oh : '0);

   rr_picker #(
      .N    (N),
      .SELW (SELW)
   ) u_picker (
      .req   (w_elig),
      .ptr   (r_ptr),
      .win   (w_pick),
      .valid (w_pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_ok    <= 1'b0;
         r_mask  <= 1'b0;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_idx   <= w_idx_nx;
         r_ok    <= w_ok_nx;
         r_mask  <= w_mask_nx;
         r_timer <= w_timer_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_idx_nx   = r_idx;
      w_ok_nx    = r_ok;
      w_mask_nx  = r_mask;
      w_timer_nx = r_timer;
      case (r_state)
         IDLE: begin
            w_mask_nx = 1'b0;
            if (motor_ready && w_pick_valid) begin
               w_idx_nx   = w_pick;
               w_state_nx = GO;
            end
         end
         GO: begin
            w_timer_nx = '0;
            w_state_nx = WAIT;
         end
         WAIT: begin
            w_timer_nx = r_timer + TW'(1);
            // A done landing on the last timer count still counts as success.
            if (motor_done) begin
               w_ok_nx    = 1'b1;
               w_state_nx = DONE;
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_ok_nx    = 1'b0;
               w_state_nx = DONE;
            end
         end
         DONE: begin
            w_ptr_nx   = (r_idx == SELW'(N - 1)) ? '0 : r_idx + SELW'(1);
            w_mask_nx  = 1'b1;
            w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != IDLE);
      motor_go  = (r_state == GO);
      motor_sel = busy ? r_idx : '0;
      grant     = busy ? w_oh : '0;
      ack       = (r_state == DONE && r_ok) ? w_oh : '0;
      fault     = (r_state == DONE && !r_ok) ? w_oh : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_dispense_arbiter.sv
`default_nettype none
// --------------------------------------------------------------------------
// tb_dispense_arbiter: directed vector table plus multi-cycle sequences.
// Rev 1.0
// --------------------------------------------------------------------------
module tb_dispense_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic       motor_ready = 1'b0;
   logic       motor_done = 1'b0;
   logic       motor_go;
   logic [1:0] motor_sel;
   logic [3:0] grant, ack, fault;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       done;
      logic       go;
      logic [3:0] grant;
      logic [1:0] sel;
      logic [3:0] ack;
      logic [3:0] fault;
      logic       busy;
   } vec_t;

   vec_t tbl [18];

   dispense_arbiter #(
      .N       (4),
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .motor_ready (motor_ready),
      .motor_done  (motor_done),
      .motor_go    (motor_go),
      .motor_sel   (motor_sel),
      .grant       (grant),
      .ack         (ack),
      .fault       (fault),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_go();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!motor_go && n < 12);
      check("go_seen", 32'(motor_go), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      motor_ready = 1'b0;
      motor_done = 1'b0;
      step();
      check("rst_go", 32'(motor_go), 32'd0);
      check("rst_sel", 32'(motor_sel), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // req, rdy, done | go, grant, sel, ack, fault, busy
      tbl[0]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b1};
      tbl[1]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b1};
      tbl[2]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b1};
      tbl[3]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b1};
      tbl[4]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 4'b0001, 4'b0000, 1'b1};
      tbl[5]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0};
      tbl[6]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0};
      tbl[7]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0};
      for (int i = 8; i < 13; i++)
         tbl[i] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0};
      tbl[13] = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0000, 4'b0000, 1'b1};
      tbl[14] = '{4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 4'b0000, 4'b0000, 1'b1};
      tbl[15] = '{4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 4'b0010, 4'b0000, 1'b1};
      tbl[16] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0};
      tbl[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0};

      do_reset();

      for (int i = 0; i < 18; i++) begin
         req = tbl[i].req;
         motor_ready = tbl[i].rdy;
         motor_done = tbl[i].done;
         step();
         check($sformatf("v%0d_go", i), 32'(motor_go), 32'(tbl[i].go));
         check($sformatf("v%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
         check($sformatf("v%0d_sel", i), 32'(motor_sel), 32'(tbl[i].sel));
         check($sformatf("v%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
         check($sformatf("v%0d_fault", i), 32'(fault), 32'(tbl[i].fault));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      end

      // Round robin with all four channels contending
      do_reset();
      req = 4'b1111;
      motor_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         logic [3:0] exp_oh;
         exp_oh = 4'b0001 << (g % 4);
         wait_go();
         check($sformatf("rr%0d_grant", g), 32'(grant), 32'(exp_oh));
         step();
         motor_done = 1'b1;
         step();
         motor_done = 1'b0;
         check($sformatf("rr%0d_ack", g), 32'(ack), 32'(exp_oh));
         req = 4'b1111 & ~exp_oh;
         step();
         req = 4'b1111;
      end
      req = '0;
      step();
      step();

      // Timeout: no motor_done ever
      begin
         int n;
         int acks;
         n = 0;
         acks = 0;
         req = 4'b0100;
         wait_go();
         check("to_grant", 32'(grant), 32'b0100);
         for (int c = 0; c < 30; c++) begin
            step();
            n++;
            if (ack != 0) acks++;
            if (fault != 0) break;
         end
         check("to_cycles", 32'(n), 32'd9);
         check("to_fault", 32'(fault), 32'b0100);
         check("to_noack", 32'(acks), 32'd0);
         req = '0;
         step();
         check("to_idle", 32'(busy), 32'd0);
         check("to_pulse", 32'(fault), 32'd0);
      end

      // motor_done on the final timer count wins over the timeout
      req = 4'b0100;
      wait_go();
      for (int c = 0; c < 8; c++) step();
      check("sim_busy", 32'(busy), 32'd1);
      motor_done = 1'b1;
      step();
      motor_done = 1'b0;
      check("sim_ack", 32'(ack), 32'b0100);
      check("sim_fault", 32'(fault), 32'd0);
      req = '0;
      step();
      step();

      // Asynchronous reset in the middle of WAIT
      req = 4'b1001;
      wait_go();
      check("ar_grant", 32'(grant), 32'b1000);
      check("ar_sel", 32'(motor_sel), 32'd3);
      step();
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_grant0", 32'(grant), 32'd0);
      check("ar_sel0", 32'(motor_sel), 32'd0);
      check("ar_go", 32'(motor_go), 32'd0);
      req = '0;
      #2;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("ar_post%0d", c), 32'({ack, fault, busy}), 32'd0);
      end
      req = 4'b1001;
      wait_go();
      check("ar_ptr0", 32'(grant), 32'b0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
